// File: rtl/arm_lsu_if.sv
// Core-side request/response and memory-side beat interfaces for arm_lsu.
interface arm_lsu_req_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface arm_lsu_mem_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/arm_lsu.sv
// Load/store unit: request handshake, wait-stated memory beats, per-beat timeout.
// Define ARM_LSU_SPLIT_EN to run misaligned accesses as two beats instead of rejecting them.
module arm_lsu #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  arm_lsu_req_if.slave  core_if,
  arm_lsu_mem_if.master mem_if
);
  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW:0] TMO_LIM = (TW + 1)'(TIMEOUT);
`ifdef ARM_LSU_SPLIT_EN
  localparam int unsigned SPAN_W = 2 * NB;
`else
  localparam int unsigned SPAN_W = NB;
`endif

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_e;

  state_e            state_q;
  logic              ready_q, resp_valid_q, resp_err_q;
  logic [31:0]       resp_rdata_q, rbuf_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [NB-1:0]     mem_be_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [TW-1:0]     tmo_q;
  logic              write_q, signed_q;
  logic [1:0]        size_q;
  logic [OW-1:0]     off_q;
`ifdef ARM_LSU_SPLIT_EN
  logic [NB-1:0]     be_hi_q;
`endif

  logic [OW-1:0]     off_c;
  logic              illegal_c, tmo_hit_c, go_beat2_c;
  logic [3:0]        size_mask_c;
  logic [SPAN_W-1:0] be_span_c;
  logic [ADDR_W-1:0] base_c;
  logic [DATA_W-1:0] wdata_rep_c;
  logic [1:0]        widx_c, ridx_c;
  logic [31:0]       rbuf_c, ext_c;

  // Request decode: lane span, aligned base and store data placed on its lanes
  always_comb begin
    off_c     = core_if.req_addr[OW-1:0];
    illegal_c = (core_if.req_size == 2'd3);
`ifndef ARM_LSU_SPLIT_EN
    illegal_c = illegal_c
              | (core_if.req_size == 2'd1 && core_if.req_addr[0])
              | (core_if.req_size == 2'd2 && core_if.req_addr[1:0] != 2'b00);
`endif
    case (core_if.req_size)
      2'd0:    size_mask_c = 4'b0001;
      2'd1:    size_mask_c = 4'b0011;
      default: size_mask_c = 4'b1111;
    endcase
    be_span_c = SPAN_W'(size_mask_c) << off_c;
    base_c    = {core_if.req_addr[ADDR_W-1:OW], OW'(0)};
    widx_c    = 2'b00;
    for (int j = 0; j < int'(NB); j++) begin
      widx_c = 2'(32'(j) - 32'(off_c)) & size_mask_c[2:1];
      wdata_rep_c[8*j +: 8] = core_if.req_wdata[8*widx_c +: 8];
    end
  end

  // Merge acked lanes into the little-endian load buffer
  always_comb begin
    rbuf_c = rbuf_q;
    ridx_c = 2'b00;
    for (int j = 0; j < int'(NB); j++) begin
      if (mem_be_q[j]) begin
        ridx_c = 2'(32'(j) - 32'(off_q));
        rbuf_c[8*ridx_c +: 8] = mem_if.mem_rdata[8*j +: 8];
      end
    end
    case (size_q)
      2'd0:    ext_c = signed_q ? {{24{rbuf_c[7]}}, rbuf_c[7:0]} : {24'd0, rbuf_c[7:0]};
      2'd1:    ext_c = signed_q ? {{16{rbuf_c[15]}}, rbuf_c[15:0]} : {16'd0, rbuf_c[15:0]};
      default: ext_c = rbuf_c;
    endcase
  end

  always_comb begin
    tmo_hit_c = (TIMEOUT != 0) && (({1'b0, tmo_q} + (TW + 1)'(1)) == TMO_LIM);
`ifdef ARM_LSU_SPLIT_EN
    go_beat2_c = (state_q == BEAT1) && (be_hi_q != '0);
`else
    go_beat2_c = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      tmo_q        <= '0;
      write_q      <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= 2'd0;
      off_q        <= '0;
      rbuf_q       <= '0;
`ifdef ARM_LSU_SPLIT_EN
      be_hi_q      <= '0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (core_if.req_valid && ready_q) begin
            ready_q  <= 1'b0;
            write_q  <= core_if.req_write;
            signed_q <= core_if.req_signed;
            size_q   <= core_if.req_size;
            off_q    <= off_c;
            rbuf_q   <= '0;
`ifdef ARM_LSU_SPLIT_EN
            be_hi_q  <= be_span_c[2*NB-1:NB];
`endif
            if (illegal_c) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q     <= BEAT1;
              mem_req_q   <= 1'b1;
              mem_we_q    <= core_if.req_write;
              mem_addr_q  <= base_c;
              mem_be_q    <= be_span_c[NB-1:0];
              mem_wdata_q <= wdata_rep_c;
              tmo_q       <= '0;
            end
          end
        end
        BEAT1, BEAT2: begin
          if (mem_if.mem_ack) begin
            rbuf_q <= rbuf_c;
            tmo_q  <= '0;
            if (go_beat2_c) begin
              state_q    <= BEAT2;
              mem_addr_q <= mem_addr_q + ADDR_W'(NB);
`ifdef ARM_LSU_SPLIT_EN
              mem_be_q   <= be_hi_q;
`endif
            end else begin
              state_q      <= RESP;
              mem_req_q    <= 1'b0;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= write_q ? 32'd0 : ext_c;
            end
          end else if (tmo_hit_c) begin
            // Abort: any remaining beat is skipped
            state_q      <= RESP;
            mem_req_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        RESP: begin
          state_q      <= IDLE;
          ready_q      <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_if.req_ready  = ready_q;
  assign core_if.resp_valid = resp_valid_q;
  assign core_if.resp_rdata = resp_rdata_q;
  assign core_if.resp_err   = resp_err_q;
  assign mem_if.mem_req     = mem_req_q;
  assign mem_if.mem_we      = mem_we_q;
  assign mem_if.mem_addr    = mem_addr_q;
  assign mem_if.mem_be      = mem_be_q;
  assign mem_if.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_arm_lsu.sv
// Scoreboard bench for arm_lsu: a 32-bit instance (TIMEOUT=4) and a 64-bit instance.
`timescale 1ns/1ps
module tb_arm_lsu;
  typedef struct { logic [31:0] rdata; logic err; int cyc; } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb32[$];
  exp_t sb64[$];
  exp_t e32, e64;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arm_lsu_req_if #(.ADDR_W(32))               c32 ();
  arm_lsu_mem_if #(.DATA_W(32), .ADDR_W(32))  m32 ();
  arm_lsu_req_if #(.ADDR_W(32))               c64 ();
  arm_lsu_mem_if #(.DATA_W(64), .ADDR_W(32))  m64 ();

  arm_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_lsu32 (
    .clk_i(clk), .rst_ni(rst_n), .core_if(c32), .mem_if(m32));
  arm_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(16)) u_lsu64 (
    .clk_i(clk), .rst_ni(rst_n), .core_if(c64), .mem_if(m64));

  // Response monitors: every resp_valid must match the oldest expected entry
  always @(negedge clk) begin
    if (c32.resp_valid === 1'b1) begin
      n_checks++;
      if (sb32.size() == 0) begin
        n_fail++;
        $display("FAIL resp32_unexpected: resp_valid=1 at cycle %0d, required no response", cyc);
      end else begin
        e32 = sb32.pop_front();
        if (c32.resp_rdata !== e32.rdata || c32.resp_err !== e32.err || cyc != e32.cyc) begin
          n_fail++;
          $display("FAIL resp32: rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                   c32.resp_rdata, c32.resp_err, cyc, e32.rdata, e32.err, e32.cyc);
        end
      end
    end
    if (c64.resp_valid === 1'b1) begin
      n_checks++;
      if (sb64.size() == 0) begin
        n_fail++;
        $display("FAIL resp64_unexpected: resp_valid=1 at cycle %0d, required no response", cyc);
      end else begin
        e64 = sb64.pop_front();
        if (c64.resp_rdata !== e64.rdata || c64.resp_err !== e64.err || cyc != e64.cyc) begin
          n_fail++;
          $display("FAIL resp64: rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                   c64.resp_rdata, c64.resp_err, cyc, e64.rdata, e64.err, e64.cyc);
        end
      end
    end
  end

  task automatic idle1;
    @(posedge clk); #1;
  endtask

  // Present one request to the 32-bit unit; returns the handshake cycle
  task automatic req32(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, output int n);
    n = cyc;
    c32.req_valid = 1'b1; c32.req_write = w; c32.req_size = sz;
    c32.req_signed = sg; c32.req_addr = a; c32.req_wdata = wd;
    @(posedge clk); #1;
    c32.req_valid = 1'b0; c32.req_addr = 32'hFFFF_FFFF; c32.req_wdata = 32'h5A5A_5A5A;
  endtask

  // Memory side of one 32-bit beat with a given number of wait states
  task automatic beat32(input logic [31:0] ea, input logic [3:0] ebe, input logic ewe,
                        input logic [31:0] ewd, input logic [31:0] rd, input int waits);
    for (int i = 0; i <= waits; i++) begin
      m32.mem_ack   = (i == waits);
      m32.mem_rdata = (i == waits) ? rd : 32'hDEAD_BEEF;
      @(negedge clk);
      n_checks++;
      if (m32.mem_req !== 1'b1 || m32.mem_addr !== ea || m32.mem_be !== ebe ||
          m32.mem_we !== ewe || (ewe && m32.mem_wdata !== ewd) || c32.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL beat32 @%h: req=%b addr=%h be=%b we=%b wdata=%h ready=%b, required req=1 addr=%h be=%b we=%b wdata=%h ready=0",
                 ea, m32.mem_req, m32.mem_addr, m32.mem_be, m32.mem_we, m32.mem_wdata,
                 c32.req_ready, ea, ebe, ewe, ewd);
      end
      @(posedge clk); #1;
    end
    m32.mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (c32.req_ready !== 1'b1 || c32.resp_valid !== 1'b0 || c32.resp_err !== 1'b0 ||
        c32.resp_rdata !== 32'd0 || m32.mem_req !== 1'b0 || m32.mem_we !== 1'b0 ||
        m32.mem_addr !== 32'd0 || m32.mem_be !== 4'd0 || m32.mem_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset32: ready=%b rv=%b err=%b rdata=%h req=%b we=%b addr=%h be=%b wdata=%h, required 1 and zeros",
               c32.req_ready, c32.resp_valid, c32.resp_err, c32.resp_rdata, m32.mem_req,
               m32.mem_we, m32.mem_addr, m32.mem_be, m32.mem_wdata);
    end
    n_checks++;
    if (c64.req_ready !== 1'b1 || m64.mem_req !== 1'b0 || m64.mem_be !== 8'd0 || m64.mem_wdata !== 64'd0) begin
      n_fail++;
      $display("FAIL reset64: ready=%b req=%b be=%b wdata=%h, required 1 and zeros",
               c64.req_ready, m64.mem_req, m64.mem_be, m64.mem_wdata);
    end
    rst_n = 1'b1;
    idle1();
  endtask

  task automatic test_load;
    int n;
    req32(1'b0, 2'd0, 1'b1, 32'h103, 32'd0, n); sb32.push_back('{32'hFFFF_FF80, 1'b0, n + 2});
    beat32(32'h100, 4'b1000, 1'b0, 32'd0, 32'h80FF_0000, 0); idle1();
    req32(1'b0, 2'd0, 1'b0, 32'h101, 32'd0, n); sb32.push_back('{32'h0000_0056, 1'b0, n + 2});
    beat32(32'h100, 4'b0010, 1'b0, 32'd0, 32'h1234_5678, 0); idle1();
    req32(1'b0, 2'd1, 1'b1, 32'h102, 32'd0, n); sb32.push_back('{32'hFFFF_8765, 1'b0, n + 2});
    beat32(32'h100, 4'b1100, 1'b0, 32'd0, 32'h8765_4321, 0); idle1();
    req32(1'b0, 2'd1, 1'b0, 32'h100, 32'd0, n); sb32.push_back('{32'h0000_4321, 1'b0, n + 2});
    beat32(32'h100, 4'b0011, 1'b0, 32'd0, 32'h8765_4321, 0); idle1();
    req32(1'b0, 2'd2, 1'b1, 32'h104, 32'd0, n); sb32.push_back('{32'hCAFE_F00D, 1'b0, n + 4});
    beat32(32'h104, 4'b1111, 1'b0, 32'd0, 32'hCAFE_F00D, 2); idle1();
  endtask

  task automatic test_store;
    int n;
    req32(1'b1, 2'd0, 1'b0, 32'h102, 32'h1234_56A5, n); sb32.push_back('{32'd0, 1'b0, n + 2});
    beat32(32'h100, 4'b0100, 1'b1, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 0); idle1();
    req32(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_BEEF, n); sb32.push_back('{32'd0, 1'b0, n + 3});
    beat32(32'h10, 4'b1100, 1'b1, 32'hBEEF_BEEF, 32'hFFFF_FFFF, 1); idle1();
  endtask

  task automatic test_bus64;
    int n;
    n = cyc;
    c64.req_valid = 1'b1; c64.req_write = 1'b1; c64.req_size = 2'd1; c64.req_signed = 1'b0;
    c64.req_addr = 32'h206; c64.req_wdata = 32'h0000_BEEF;
    sb64.push_back('{32'd0, 1'b0, n + 2});
    idle1();
    c64.req_valid = 1'b0; m64.mem_ack = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m64.mem_req !== 1'b1 || m64.mem_we !== 1'b1 || m64.mem_addr !== 32'h200 ||
        m64.mem_be !== 8'b1100_0000 || m64.mem_wdata !== 64'hBEEF_BEEF_BEEF_BEEF) begin
      n_fail++;
      $display("FAIL store64: req=%b we=%b addr=%h be=%b wdata=%h, required 1 1 00000200 11000000 beefbeefbeefbeef",
               m64.mem_req, m64.mem_we, m64.mem_addr, m64.mem_be, m64.mem_wdata);
    end
    idle1(); m64.mem_ack = 1'b0; idle1();
    n = cyc;
    c64.req_valid = 1'b1; c64.req_write = 1'b0; c64.req_size = 2'd2; c64.req_addr = 32'h20C;
    sb64.push_back('{32'h1122_3344, 1'b0, n + 2});
    idle1();
    c64.req_valid = 1'b0; m64.mem_ack = 1'b1; m64.mem_rdata = 64'h1122_3344_5566_7788;
    @(negedge clk);
    n_checks++;
    if (m64.mem_req !== 1'b1 || m64.mem_addr !== 32'h208 || m64.mem_be !== 8'b1111_0000) begin
      n_fail++;
      $display("FAIL load64: req=%b addr=%h be=%b, required 1 00000208 11110000",
               m64.mem_req, m64.mem_addr, m64.mem_be);
    end
    idle1(); m64.mem_ack = 1'b0; idle1();
  endtask

  task automatic test_timeout;
    int n;
    int hi;
    hi = 0;
    m32.mem_ack = 1'b0;
    req32(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, n); sb32.push_back('{32'd0, 1'b1, n + 5});
    for (int i = 0; i < 10; i++) begin
      m32.mem_rdata = $urandom;
      @(negedge clk);
      if (m32.mem_req === 1'b1) hi++;
      idle1();
    end
    n_checks++;
    if (hi != 4) begin
      n_fail++;
      $display("FAIL timeout_req_cycles: mem_req high %0d cycles, required 4", hi);
    end
    // Ack on the cycle the counter would expire: ack takes priority
    req32(1'b0, 2'd2, 1'b0, 32'h44, 32'd0, n); sb32.push_back('{32'h7654_3210, 1'b0, n + 5});
    beat32(32'h44, 4'b1111, 1'b0, 32'd0, 32'h7654_3210, 3); idle1();
  endtask

  task automatic test_misaligned;
    int n;
`ifdef ARM_LSU_SPLIT_EN
    req32(1'b0, 2'd2, 1'b0, 32'h3, 32'd0, n); sb32.push_back('{32'hDDCC_BBAA, 1'b0, n + 3});
    beat32(32'h0, 4'b1000, 1'b0, 32'd0, 32'hAA00_0000, 0);
    beat32(32'h4, 4'b0111, 1'b0, 32'd0, 32'h00DD_CCBB, 0); idle1();
    req32(1'b1, 2'd1, 1'b0, 32'h7, 32'h0000_1122, n); sb32.push_back('{32'd0, 1'b0, n + 4});
    beat32(32'h4, 4'b1000, 1'b1, 32'h2211_2211, 32'd0, 1);
    beat32(32'h8, 4'b0001, 1'b1, 32'h2211_2211, 32'd0, 0); idle1();
`else
    req32(1'b0, 2'd2, 1'b0, 32'h3, 32'd0, n); sb32.push_back('{32'd0, 1'b1, n + 1});
    @(negedge clk);
    n_checks++;
    if (m32.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL misaligned_word_bus: mem_req=%b, required 0", m32.mem_req);
    end
    idle1();
    req32(1'b0, 2'd1, 1'b1, 32'h5, 32'd0, n); sb32.push_back('{32'd0, 1'b1, n + 1});
    @(negedge clk);
    n_checks++;
    if (m32.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL misaligned_half_bus: mem_req=%b, required 0", m32.mem_req);
    end
    idle1();
`endif
    req32(1'b0, 2'd3, 1'b0, 32'h100, 32'd0, n); sb32.push_back('{32'd0, 1'b1, n + 1});
    @(negedge clk);
    n_checks++;
    if (m32.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL size3_bus: mem_req=%b, required 0", m32.mem_req);
    end
    idle1();
  endtask

  task automatic test_reset_mid_beat;
    int n;
    m32.mem_ack = 1'b0;
    req32(1'b0, 2'd2, 1'b0, 32'h80, 32'd0, n);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (m32.mem_req !== 1'b0 || c32.resp_valid !== 1'b0 || c32.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_beat: req=%b rv=%b ready=%b, required 0 0 1",
               m32.mem_req, c32.resp_valid, c32.req_ready);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) idle1();
    req32(1'b0, 2'd2, 1'b0, 32'h84, 32'd0, n); sb32.push_back('{32'h0BAD_CAFE, 1'b0, n + 2});
    beat32(32'h84, 4'b1111, 1'b0, 32'd0, 32'h0BAD_CAFE, 0); idle1();
  endtask

  task automatic test_back_to_back;
    int n;
    req32(1'b0, 2'd2, 1'b0, 32'h200, 32'd0, n); sb32.push_back('{32'h0102_0304, 1'b0, n + 2});
    beat32(32'h200, 4'b1111, 1'b0, 32'd0, 32'h0102_0304, 0);
    @(negedge clk);
    n_checks++;
    if (c32.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_in_resp: req_ready=%b, required 0", c32.req_ready);
    end
    idle1();
    n_checks++;
    if (c32.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_in_idle: req_ready=%b, required 1", c32.req_ready);
    end
    req32(1'b0, 2'd2, 1'b0, 32'h204, 32'd0, n); sb32.push_back('{32'h0A0B_0C0D, 1'b0, n + 2});
    beat32(32'h204, 4'b1111, 1'b0, 32'd0, 32'h0A0B_0C0D, 0); idle1();
  endtask

  initial begin
    rst_n = 1'b0;
    c32.req_valid = 1'b0; c32.req_write = 1'b0; c32.req_size = 2'd0; c32.req_signed = 1'b0;
    c32.req_addr = 32'd0; c32.req_wdata = 32'd0;
    c64.req_valid = 1'b0; c64.req_write = 1'b0; c64.req_size = 2'd0; c64.req_signed = 1'b0;
    c64.req_addr = 32'd0; c64.req_wdata = 32'd0;
    m32.mem_ack = 1'b0; m32.mem_rdata = 32'd0;
    m64.mem_ack = 1'b0; m64.mem_rdata = 64'd0;
    #1;
    test_reset();
    test_load();
    test_store();
    test_bus64();
    test_timeout();
    test_misaligned();
    test_reset_mid_beat();
    test_back_to_back();
    repeat (3) idle1();
    n_checks++;
    if (sb32.size() != 0 || sb64.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: pending32=%0d pending64=%0d, required 0 and 0",
               sb32.size(), sb64.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
